// File: rtl/sync_ram_ctrl.sv
// Single-port word RAM with byte-enable writes, a fixed-latency read pipeline
// and a self-clearing INIT sequence entered on reset or on clr_req.
module sync_ram_ctrl #(
  parameter int ADDR_W = 4,
  parameter int WORD_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [WORD_W-1:0]     req_wdata,
  input  logic [WORD_W/8-1:0]   req_be,
  input  logic                  clr_req,
  output logic                  rsp_valid,
  output logic [WORD_W-1:0]     rsp_rdata,
  output logic                  init_busy
);

  localparam int NB    = WORD_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [RD_LAT-1:0]   pv_q;
  logic [WORD_W-1:0]   pd_q [RD_LAT];
  logic                wr_acc, rd_acc;

  assign req_ready = (state_q == S_RUN);
  assign init_busy = (state_q == S_INIT);
  assign wr_acc    = req_valid && req_ready && req_we;
  assign rd_acc    = req_valid && req_ready && !req_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (clr_req) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory is never reset; the INIT sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) mem_q[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Data stages load only behind a valid, so the last stage holds the previous response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= rd_acc;
      if (rd_acc) pd_q[0] <= mem_q[req_addr];
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign rsp_valid = pv_q[RD_LAT-1];
  assign rsp_rdata = pd_q[RD_LAT-1];

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Directed plus randomized bench for sync_ram_ctrl against a cycle-level
// behavioural memory model with a queue of expected responses.
module tb_sync_ram_ctrl;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_be = '0;
  logic          clr_req = 1'b0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          init_busy;

  sync_ram_ctrl #(.ADDR_W(AW), .WORD_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .clr_req(clr_req),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [DW-1:0] d; } pend_t;

  logic [DW-1:0] mdl_mem [DEPTH];
  pend_t         pend [$];
  int            cyc = 0;
  int            init_left = DEPTH;
  logic [DW-1:0] last_d = '0;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
  endtask

  // One clock: drive inputs, advance the model at the edge, check all outputs just after it.
  task automatic tick(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [1:0] be, input logic c);
    logic          acc;
    logic          exp_v;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be; clr_req = c;
    @(posedge clk);
    cyc++;
    acc = v && (init_left == 0);
    if (acc && we) begin
      for (int b = 0; b < 2; b++)
        if (be[b]) mdl_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    if (acc && !we) pend.push_back('{due: cyc + RL - 1, d: mdl_mem[a]});
    if (init_left == 0 && c) begin
      model_clear();
      init_left = DEPTH;
    end else if (init_left > 0) begin
      init_left--;
    end
    exp_v = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_v  = 1'b1;
      last_d = pend[0].d;
      void'(pend.pop_front());
    end
    #1;
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
    chk("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, last_d});
    chk("req_ready", {31'b0, req_ready}, {31'b0, init_left == 0});
    chk("init_busy", {31'b0, init_busy}, {31'b0, init_left != 0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    tick(1'b1, 1'b1, a, d, be, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    tick(1'b1, 1'b0, a, '0, '0, 1'b0);
  endtask

  task automatic wait_init();
    int n = 0;
    while (init_left > 0 && n < 40) begin
      idle(1);
      n++;
    end
    chk("init_done", {31'b0, init_left == 0}, 32'd1);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must drop before any edge.
  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0; clr_req = 1'b0;
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'b0, rsp_rdata}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_init_busy", {31'b0, init_busy}, 32'd1);
    pend.delete();
    last_d = '0;
    init_left = DEPTH;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    wait_init();
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(4);

    wr(4'd3, 16'hBEEF, 2'b11);
    rd(4'd3);
    idle(1);
    chk("beef_rdata", {16'b0, rsp_rdata}, 32'h0000BEEF);
    idle(2);

    wr(4'd5, 16'h1234, 2'b11);
    wr(4'd5, 16'hAB00, 2'b10);
    rd(4'd5);
    idle(3);
    chk("merge_rdata", {16'b0, rsp_rdata}, 32'h0000AB34);

    for (int i = 0; i < 4; i++) wr(AW'(i), 16'h0A00 + 16'(i), 2'b11);
    for (int i = 0; i < 4; i++) rd(AW'(i));
    idle(4);
    chk("b2b_last", {16'b0, rsp_rdata}, 32'h00000A03);

    wr(4'd3, 16'hBEEF, 2'b11);
    wr(4'd7, 16'hFFFF, 2'b00);
    rd(4'd7);
    rd(4'd3);
    tick(1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(1);
    chk("preclear_rdata", {16'b0, rsp_rdata}, 32'h0000BEEF);
    wait_init();
    rd(4'd3);
    idle(3);

    wr(4'd9, 16'h5A5A, 2'b11);
    tick(1'b1, 1'b1, 4'd9, 16'hC3C3, 2'b11, 1'b1);
    wait_init();
    rd(4'd9);
    idle(3);

    wr(4'd2, 16'h7777, 2'b11);
    rd(4'd2);
    rd(4'd2);
    do_reset();
    wait_init();
    idle(4);

    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
           16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 59) == 0);
    end
    idle(4);
    wait_init();
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_ram_ctrl.md
SYNC_RAM_CTRL -- requirements
Module: sync_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W words, exactly, no extra entry.
REQ-002 SHALL have parameter WORD_W, default 16: data width; SHALL be a multiple of 8; NB = WORD_W/8 byte lanes.
REQ-003 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal range 1..3.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, as listed below.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  word address.
REQ-011 req_wdata  in  WORD_W  write data.
REQ-012 req_be  in  NB  byte enables for writes; bit i enables bits [8i+7:8i].
REQ-013 clr_req  in  1  single-cycle pulse that re-zeroes the whole memory.
REQ-014 rsp_valid  out  1  read data valid, one cycle per accepted read.
REQ-015 rsp_rdata  out  WORD_W  read data.
REQ-016 init_busy  out  1  memory-clear sequence in progress.

Function
REQ-017 Controller SHALL be an FSM with states INIT and RUN; req_ready = (state == RUN); init_busy = (state == INIT).
REQ-018 INIT: SHALL write zero to address cnt and increment cnt, one word per cycle from 0 to DEPTH-1; after writing DEPTH-1 it SHALL enter RUN. INIT lasts exactly DEPTH cycles.
REQ-019 RUN: clr_req=1 SHALL clear cnt to 0 and enter INIT on the next edge. clr_req SHALL be ignored while in INIT.
REQ-020 A request is accepted when req_valid && req_ready; the pipeline SHALL accept one request per cycle with no bubbles.
REQ-021 Accepted write SHALL update only the byte lanes whose req_be bit is 1; req_be=0 SHALL leave memory unchanged. Writes SHALL produce no response.
REQ-022 Read accepted at edge N SHALL assert rsp_valid for exactly one cycle after edge N+RD_LAT-1, i.e. RD_LAT cycles later.
REQ-023 Read data SHALL reflect every write accepted before the read; a write at edge N SHALL be visible to a read accepted at edge N+1.
REQ-024 Responses SHALL return in request order. rsp_valid has no backpressure.
REQ-025 rsp_rdata SHALL hold its last value while rsp_valid=0.
REQ-026 A request accepted in the same cycle as clr_req SHALL complete normally; the clear starts on the next edge and overwrites that write.
REQ-027 Reads already in the pipeline when INIT is entered via clr_req SHALL still complete with their pre-clear data.
REQ-028 Out-of-range addresses cannot occur: req_addr SHALL index the full DEPTH range.

Reset
REQ-029 On rst=1, immediately and asynchronously: state=INIT, cnt=0, read pipeline valid bits cleared, rsp_valid=0, rsp_rdata=0, req_ready=0, init_busy=1.
REQ-030 Memory contents SHALL NOT be reset directly; they SHALL be zeroed by the INIT sequence after rst deasserts.
REQ-031 rst asserted mid-operation SHALL discard all in-flight reads; no response from before the reset SHALL appear after release.

Verification
REQ-032 All scenarios use ADDR_W=4, WORD_W=16, RD_LAT=2.
REQ-033 Release rst -> init_busy=1 for 16 cycles, then req_ready=1; reading addresses 0..15 -> all return 0x0000.
REQ-034 Write addr 3 = 0xBEEF with be=11, then read addr 3 on the next cycle -> rsp_valid 2 cycles after read acceptance, rsp_rdata = 0xBEEF.
REQ-035 Write addr 5 = 0x1234 with be=11, then write addr 5 = 0xAB00 with be=10, then read addr 5 -> 0xAB34.
REQ-036 Read addrs 0,1,2,3 back-to-back after writing them with 0x0A00..0x0A03 -> 4 consecutive rsp_valid cycles returning 0x0A00, 0x0A01, 0x0A02, 0x0A03 in order.
REQ-037 Read addr 3 (=0xBEEF), then pulse clr_req one cycle later -> the read returns 0xBEEF; init_busy=1 for 16 cycles; a subsequent read of addr 3 returns 0x0000.
REQ-038 Issue a read and assert rst one cycle later -> rsp_valid=0 at once; no rsp_valid pulse before the next accepted read after INIT completes.
